// File: rtl/weight_ram_sequencer.sv
// Weight RAM row sequencer: issues one linear read sweep and tags the returning rows.
// Optional consumer back-pressure port i_stall is enabled with `define WRAM_SEQ_STALL_EN.
module weight_ram_sequencer #(
  parameter int NROWS      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_n_rows,
`ifdef WRAM_SEQ_STALL_EN
  input  logic                  i_stall,
`endif
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic                  o_rd_en,
  output logic                  o_row_valid,
  output logic [ADDR_WIDTH-1:0] o_row_index,
  output logic                  o_row_last,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] LP_NROWS = (ADDR_WIDTH+1)'(NROWS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_n_eff;
  logic [ADDR_WIDTH:0]   w_n_eff_nxt;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   w_issued_nxt;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [ADDR_WIDTH-1:0] w_address_nxt;
  logic                  r_rd_en;
  logic                  w_rd_en_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_row_valid;
  logic [ADDR_WIDTH-1:0] r_row_index;
  logic                  r_row_last;
  logic [ADDR_WIDTH:0]   w_n_clamp;
  logic                  w_stall;

`ifdef WRAM_SEQ_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_n_clamp = (i_n_rows > LP_NROWS) ? LP_NROWS : i_n_rows;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_n_eff_nxt   = r_n_eff;
    w_issued_nxt  = r_issued;
    w_address_nxt = r_address;
    w_rd_en_nxt   = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_n_eff_nxt = w_n_clamp;
          w_busy_nxt  = 1'b1;
          if (w_n_clamp == {(ADDR_WIDTH+1){1'b0}}) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_RUN;
            w_address_nxt = {ADDR_WIDTH{1'b0}};
            w_rd_en_nxt   = 1'b1;
            w_issued_nxt  = (ADDR_WIDTH+1)'(1'b1);
          end
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_RUN: begin
        // Once every row is issued the stall input no longer matters.
        if (r_issued == r_n_eff) begin
          w_state_nxt = S_DRAIN;
        end else if (w_stall) begin
          w_rd_en_nxt = 1'b0;
        end else begin
          w_address_nxt = r_address + ADDR_WIDTH'(1'b1);
          w_rd_en_nxt   = 1'b1;
          w_issued_nxt  = r_issued + (ADDR_WIDTH+1)'(1'b1);
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; row tags follow the one-cycle RAM read latency.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_n_eff     <= {(ADDR_WIDTH+1){1'b0}};
      r_issued    <= {(ADDR_WIDTH+1){1'b0}};
      r_address   <= {ADDR_WIDTH{1'b0}};
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_row_valid <= 1'b0;
      r_row_index <= {ADDR_WIDTH{1'b0}};
      r_row_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_n_eff     <= w_n_eff_nxt;
      r_issued    <= w_issued_nxt;
      r_address   <= w_address_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_row_valid <= r_rd_en;
      r_row_index <= r_address;
      r_row_last  <= r_rd_en && (r_issued == r_n_eff);
    end
  end

  assign o_address   = r_address;
  assign o_rd_en     = r_rd_en;
  assign o_row_valid = r_row_valid;
  assign o_row_index = r_row_index;
  assign o_row_last  = r_row_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_weight_ram_sequencer.sv
// Self-checking bench for weight_ram_sequencer: directed corner sweeps plus randomized
// sweeps checked cycle by cycle against an issue-schedule model of the sweep.
module tb_weight_ram_sequencer;
  localparam int NROWS = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   n_rows;
`ifdef WRAM_SEQ_STALL_EN
  logic          stall;
`endif
  logic [AW-1:0] address;
  logic          rd_en;
  logic          row_valid;
  logic [AW-1:0] row_index;
  logic          row_last;
  logic          busy;
  logic          done;

  logic [15:0]   ram_mem [NROWS];
  logic [15:0]   ram_q;

  int n_checks = 0;
  int n_errors = 0;
  int prev_addr = 0;

  always #5 clk = ~clk;

  weight_ram_sequencer #(.NROWS(NROWS), .ADDR_WIDTH(AW)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_n_rows    (n_rows),
`ifdef WRAM_SEQ_STALL_EN
    .i_stall     (stall),
`endif
    .o_address   (address),
    .o_rd_en     (rd_en),
    .o_row_valid (row_valid),
    .o_row_index (row_index),
    .o_row_last  (row_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  // Weight RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) ram_q <= ram_mem[address];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " idle busy"}, 32'(busy), 0);
    check_eq({tag, " idle done"}, 32'(done), 0);
    check_eq({tag, " idle rd_en"}, 32'(rd_en), 0);
    check_eq({tag, " idle row_valid"}, 32'(row_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " address"}, 32'(address), 0);
    check_eq({tag, " rd_en"}, 32'(rd_en), 0);
    check_eq({tag, " row_valid"}, 32'(row_valid), 0);
    check_eq({tag, " row_index"}, 32'(row_index), 0);
    check_eq({tag, " row_last"}, 32'(row_last), 0);
    check_eq({tag, " busy"}, 32'(busy), 0);
    check_eq({tag, " done"}, 32'(done), 0);
  endtask

  // One sweep. stall_kind: 0 none, 1 random, 2 three cycles after address 7.
  task automatic run_sweep(input int n_req, input bit spam, input int stall_kind, input int gap);
    int  n_eff;
    int  done_c;
    int  k;
    int  c;
    int  issue_c [NROWS];
    bit  smask [128];
    int  exp_rd;
    int  exp_addr;
    int  exp_rv;
    int  exp_idx;
    string tg;

    repeat (gap) tick();
    tg = $sformatf("n%0d", n_req);
    check_idle(tg);

    n_eff = (n_req > NROWS) ? NROWS : n_req;
    for (int i = 0; i < 128; i++) smask[i] = 1'b0;
`ifdef WRAM_SEQ_STALL_EN
    if (stall_kind == 1) begin
      for (int i = 0; i < 128; i++) smask[i] = ($urandom_range(0, 3) == 0);
    end else if (stall_kind == 2) begin
      smask[7] = 1'b1;
      smask[8] = 1'b1;
      smask[9] = 1'b1;
    end
`endif

    // Model: row 0 issues in cycle 0; each later row issues one cycle after
    // the first unstalled cycle; the last row returns one cycle after issue
    // and done follows one cycle later.
    if (n_eff == 0) begin
      done_c = 0;
    end else begin
      issue_c[0] = 0;
      k = 1;
      c = 0;
      while (k < n_eff) begin
        if (!smask[c]) begin
          issue_c[k] = c + 1;
          k++;
        end
        c++;
      end
      done_c = issue_c[n_eff-1] + 2;
    end

    start  = 1'b1;
    n_rows = n_req[AW:0];
    tick();
    for (c = 0; c <= done_c; c++) begin
      exp_rd   = 0;
      exp_addr = prev_addr;
      exp_rv   = 0;
      exp_idx  = 0;
      for (int r = 0; r < n_eff; r++) begin
        if (issue_c[r] == c) exp_rd = 1;
        if (issue_c[r] <= c) exp_addr = r;
        if (issue_c[r] + 1 == c) begin
          exp_rv  = 1;
          exp_idx = r;
        end
      end
      tg = $sformatf("n%0d c%0d", n_req, c);
      check_eq({tg, " rd_en"}, 32'(rd_en), exp_rd);
      check_eq({tg, " address"}, 32'(address), exp_addr);
      check_eq({tg, " row_valid"}, 32'(row_valid), exp_rv);
      check_eq({tg, " row_last"}, 32'(row_last), (exp_rv == 1 && exp_idx == n_eff - 1) ? 1 : 0);
      check_eq({tg, " busy"}, 32'(busy), 1);
      check_eq({tg, " done"}, 32'(done), (c == done_c) ? 1 : 0);
      if (exp_rv == 1) begin
        check_eq({tg, " row_index"}, 32'(row_index), exp_idx);
        check_eq({tg, " ram_data"}, 32'(ram_q), 32'h0000_A500 + exp_idx);
      end
      if (spam) begin
        start  = (c == done_c) ? 1'b1 : 1'($urandom_range(0, 1));
        n_rows = 5'd3;
      end else begin
        start = 1'b0;
      end
`ifdef WRAM_SEQ_STALL_EN
      stall = smask[c];
`endif
      tick();
    end
    start = 1'b0;
`ifdef WRAM_SEQ_STALL_EN
    stall = 1'b0;
`endif
    if (n_eff > 0) prev_addr = n_eff - 1;
  endtask

  // Abort a 16-row sweep once row 5 is issued; reset also overrides a start.
  task automatic run_abort();
    start  = 1'b1;
    n_rows = 5'd16;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check_eq("abort pre address", 32'(address), 5);
    check_eq("abort pre rd_en", 32'(rd_en), 1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_all_zero("abort post");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all_zero($sformatf("abort quiet%0d", i));
    end
    prev_addr = 0;
  endtask

  initial begin
    for (int i = 0; i < NROWS; i++) ram_mem[i] = 16'hA500 + 16'(i);
    rst    = 1'b1;
    start  = 1'b0;
    n_rows = 5'd0;
`ifdef WRAM_SEQ_STALL_EN
    stall  = 1'b0;
`endif
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;

    run_sweep(16, 1'b0, 0, 0);
    run_sweep(0, 1'b0, 0, 1);
    run_sweep(20, 1'b0, 0, 0);
    run_sweep(16, 1'b1, 0, 0);
    run_abort();
    run_sweep(4, 1'b0, 0, 0);
`ifdef WRAM_SEQ_STALL_EN
    run_sweep(16, 1'b0, 2, 1);
`endif
    for (int s = 0; s < 14; s++) begin
      run_sweep($urandom_range(0, 31), 1'($urandom_range(0, 1)), 1, $urandom_range(0, 2));
    end
    tick();
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
